// File: rtl/ins_cache_ml.sv
// Multi-line direct-mapped instruction cache between the PC and AP_ctrl.
// Misses refill one line by DDR burst; also injects interrupt-service instructions.
module ins_cache_ml #(
    parameter int unsigned ISA_WIDTH       = 30,
    parameter int unsigned ADDR_WIDTH_MEM  = 16,
    parameter int unsigned DDR_ADDR_WIDTH  = 28,
    parameter int unsigned LINE_DEPTH      = 32,
    parameter int unsigned NUM_LINES       = 4,
    parameter int unsigned TOTAL_ISA_DEPTH = 128,
    parameter int unsigned ISA_BASE_ADDR   = 0,
    parameter int unsigned ADDR_SHIFT      = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ins_req,
    input  logic [ADDR_WIDTH_MEM-1:0] addr_ins,
    output logic                      ins_cache_rdy,
    output logic [ISA_WIDTH-1:0]      ins_to_apctrl,
    output logic                      ins_valid,
    output logic                      ins_err,
    input  logic                      int_req,
    input  logic [ISA_WIDTH-1:0]      int_ins,
    input  logic                      flush,
    output logic                      ins_read_req,
    output logic [DDR_ADDR_WIDTH-1:0] ins_read_addr,
    output logic [9:0]                ins_read_len,
    input  logic [ISA_WIDTH-1:0]      ins_to_cache,
    input  logic                      rd_burst_data_valid,
    output logic [15:0]               miss_cnt
);

    localparam int unsigned OFF_W     = $clog2(LINE_DEPTH);
    localparam int unsigned IDX_W     = $clog2(NUM_LINES);
    localparam int unsigned TAG_W     = ADDR_WIDTH_MEM - OFF_W - IDX_W;
    localparam int unsigned MEM_DEPTH = NUM_LINES * LINE_DEPTH;

    typedef enum logic [1:0] {StIdle, StLookup, StRefill, StRespond} state_e;

    state_e                    state;
    logic [ADDR_WIDTH_MEM-1:0] addr_q;
    logic [NUM_LINES-1:0]      valid_q;
    logic [TAG_W-1:0]          tag_q [NUM_LINES];
    logic [ISA_WIDTH-1:0]      data_q [MEM_DEPTH];
    logic [9:0]                beat_cnt;
    logic                      flush_pend;

    logic [OFF_W-1:0]          off;
    logic [IDX_W-1:0]          idx;
    logic [TAG_W-1:0]          tag;
    logic [ADDR_WIDTH_MEM-1:0] line_base;
    logic                      in_range;
    logic                      hit;
    logic                      beat_last;
    logic                      wr_en;
    int unsigned               remain;
    int unsigned               refill_len;
    int unsigned               refill_addr;

    always_comb begin
        off         = addr_q[OFF_W-1:0];
        idx         = addr_q[OFF_W +: IDX_W];
        tag         = addr_q[ADDR_WIDTH_MEM-1 -: TAG_W];
        line_base   = {tag, idx, {OFF_W{1'b0}}};
        in_range    = 32'(addr_q) < TOTAL_ISA_DEPTH;
        // A flush in the lookup cycle must not be answered from the stale line.
        hit         = valid_q[idx] && (tag_q[idx] == tag) && !flush;
        remain      = TOTAL_ISA_DEPTH - 32'(line_base);
        refill_len  = (remain < LINE_DEPTH) ? remain : LINE_DEPTH;
        refill_addr = ISA_BASE_ADDR + (32'(line_base) << ADDR_SHIFT);
        beat_last   = (beat_cnt + 10'd1) == ins_read_len;
        wr_en       = (state == StRefill) && rd_burst_data_valid;
    end

    // Data RAM carries no reset; valid bits gate every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[{idx, beat_cnt[OFF_W-1:0]}] <= ins_to_cache;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= StIdle;
            addr_q        <= '0;
            valid_q       <= '0;
            beat_cnt      <= '0;
            flush_pend    <= 1'b0;
            ins_cache_rdy <= 1'b0;
            ins_to_apctrl <= '0;
            ins_valid     <= 1'b0;
            ins_err       <= 1'b0;
            ins_read_req  <= 1'b0;
            ins_read_addr <= '0;
            ins_read_len  <= '0;
            miss_cnt      <= '0;
            for (int i = 0; i < int'(NUM_LINES); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            ins_valid <= 1'b0;
            ins_err   <= 1'b0;
            if (flush) begin
                valid_q <= '0;
            end
            case (state)
                StIdle: begin
                    if (int_req) begin
                        ins_to_apctrl <= int_ins;
                        ins_valid     <= 1'b1;
                        ins_cache_rdy <= 1'b1;
                    end else if (ins_req) begin
                        addr_q        <= addr_ins;
                        ins_cache_rdy <= 1'b0;
                        state         <= StLookup;
                    end else begin
                        ins_cache_rdy <= 1'b1;
                    end
                end
                StLookup: begin
                    if (!in_range) begin
                        ins_valid     <= 1'b1;
                        ins_err       <= 1'b1;
                        ins_to_apctrl <= '0;
                        ins_cache_rdy <= 1'b1;
                        state         <= StIdle;
                    end else if (hit) begin
                        ins_valid     <= 1'b1;
                        ins_to_apctrl <= data_q[{idx, off}];
                        ins_cache_rdy <= 1'b1;
                        state         <= StIdle;
                    end else begin
                        if (miss_cnt != 16'hFFFF) begin
                            miss_cnt <= miss_cnt + 16'd1;
                        end
                        ins_read_req  <= 1'b1;
                        ins_read_addr <= DDR_ADDR_WIDTH'(refill_addr);
                        ins_read_len  <= 10'(refill_len);
                        beat_cnt      <= '0;
                        flush_pend    <= 1'b0;
                        state         <= StRefill;
                    end
                end
                StRefill: begin
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (rd_burst_data_valid) begin
                        ins_read_req <= 1'b0;
                        beat_cnt     <= beat_cnt + 10'd1;
                        if (beat_last) begin
                            tag_q[idx]   <= tag;
                            // A flush seen anywhere in the burst leaves the line invalid.
                            valid_q[idx] <= !(flush || flush_pend);
                            state        <= StRespond;
                        end
                    end
                end
                StRespond: begin
                    ins_valid     <= 1'b1;
                    ins_to_apctrl <= data_q[{idx, off}];
                    ins_cache_rdy <= 1'b1;
                    state         <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ins_cache_ml.sv
// Directed bench for ins_cache_ml: default instance plus a TOTAL_ISA_DEPTH=140 instance
// sharing the same stimulus, used for the short-tail refill length.
module tb_ins_cache_ml;

    logic        clk;
    logic        rst;
    logic        ins_req;
    logic [15:0] addr_ins;
    logic        int_req;
    logic [29:0] int_ins;
    logic        flush;
    logic [29:0] ins_to_cache;
    logic        rd_burst_data_valid;

    logic        ins_cache_rdy, ins_valid, ins_err, ins_read_req;
    logic [29:0] ins_to_apctrl;
    logic [27:0] ins_read_addr;
    logic [9:0]  ins_read_len;
    logic [15:0] miss_cnt;

    logic        ins_cache_rdy_b, ins_valid_b, ins_err_b, ins_read_req_b;
    logic [29:0] ins_to_apctrl_b;
    logic [27:0] ins_read_addr_b;
    logic [9:0]  ins_read_len_b;
    logic [15:0] miss_cnt_b;

    int checks = 0;
    int errors = 0;

    ins_cache_ml dut (
        .clk(clk), .rst(rst), .ins_req(ins_req), .addr_ins(addr_ins),
        .ins_cache_rdy(ins_cache_rdy), .ins_to_apctrl(ins_to_apctrl),
        .ins_valid(ins_valid), .ins_err(ins_err), .int_req(int_req), .int_ins(int_ins),
        .flush(flush), .ins_read_req(ins_read_req), .ins_read_addr(ins_read_addr),
        .ins_read_len(ins_read_len), .ins_to_cache(ins_to_cache),
        .rd_burst_data_valid(rd_burst_data_valid), .miss_cnt(miss_cnt)
    );

    ins_cache_ml #(.TOTAL_ISA_DEPTH(140)) dut_b (
        .clk(clk), .rst(rst), .ins_req(ins_req), .addr_ins(addr_ins),
        .ins_cache_rdy(ins_cache_rdy_b), .ins_to_apctrl(ins_to_apctrl_b),
        .ins_valid(ins_valid_b), .ins_err(ins_err_b), .int_req(int_req), .int_ins(int_ins),
        .flush(flush), .ins_read_req(ins_read_req_b), .ins_read_addr(ins_read_addr_b),
        .ins_read_len(ins_read_len_b), .ins_to_cache(ins_to_cache),
        .rd_burst_data_valid(rd_burst_data_valid), .miss_cnt(miss_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [29:0] ddr_word(input int a);
        return 30'(32'h1550_0000 + 32'(a) * 32'd3);
    endfunction

    // Drives n beats starting at instruction index base; optional flush on beat flush_at.
    task automatic burst(input int base, input int n, input int flush_at);
        for (int i = 0; i < n; i++) begin
            rd_burst_data_valid = 1'b1;
            ins_to_cache        = ddr_word(base + i);
            flush               = (i == flush_at);
            @(negedge clk);
        end
        rd_burst_data_valid = 1'b0;
        flush               = 1'b0;
    endtask

    task automatic wait_valid(input bit use_b, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (use_b ? ins_valid_b : ins_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // Presents a request for one cycle; returns at the sample point two cycles later.
    task automatic fetch(input int a);
        ins_req  = 1'b1;
        addr_ins = 16'(a);
        @(negedge clk);
        ins_req  = 1'b0;
        @(negedge clk);
    endtask

    bit seen;

    initial begin
        rst = 1'b0; ins_req = 1'b0; addr_ins = '0; int_req = 1'b0; int_ins = '0;
        flush = 1'b0; ins_to_cache = '0; rd_burst_data_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rdy", 32'(ins_cache_rdy), 32'd0);
        check("rst_valid", 32'(ins_valid), 32'd0);
        check("rst_rreq", 32'(ins_read_req), 32'd0);
        check("rst_miss", 32'(miss_cnt), 32'd0);
        check("rst_data", 32'(ins_to_apctrl), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_rdy", 32'(ins_cache_rdy), 32'd1);

        // Cold miss at address 5, DDR slow to answer.
        fetch(5);
        check("cold_rreq", 32'(ins_read_req), 32'd1);
        check("cold_raddr", 32'(ins_read_addr), 32'd0);
        check("cold_rlen", 32'(ins_read_len), 32'd32);
        check("cold_miss", 32'(miss_cnt), 32'd1);
        check("cold_rdy", 32'(ins_cache_rdy), 32'd0);
        repeat (3) @(negedge clk);
        check("cold_rreq_hold", 32'(ins_read_req), 32'd1);
        burst(0, 32, -1);
        check("cold_rreq_drop", 32'(ins_read_req), 32'd0);
        wait_valid(1'b0, seen);
        check("cold_valid", 32'(seen), 32'd1);
        check("cold_data", 32'(ins_to_apctrl), 32'(ddr_word(5)));
        check("cold_err", 32'(ins_err), 32'd0);
        @(negedge clk);
        check("cold_pulse", 32'(ins_valid), 32'd0);

        // Hit at 6: valid exactly two cycles after the request.
        ins_req = 1'b1; addr_ins = 16'd6;
        @(negedge clk);
        ins_req = 1'b0;
        check("hit_early", 32'(ins_valid), 32'd0);
        @(negedge clk);
        check("hit_valid", 32'(ins_valid), 32'd1);
        check("hit_data", 32'(ins_to_apctrl), 32'(ddr_word(6)));
        check("hit_rreq", 32'(ins_read_req), 32'd0);
        check("hit_miss", 32'(miss_cnt), 32'd1);

        // int_req and ins_req together: interrupt instruction first.
        int_req = 1'b1; int_ins = 30'h0BAD_CAFE; ins_req = 1'b1; addr_ins = 16'd7;
        @(negedge clk);
        int_req = 1'b0;
        check("int_valid", 32'(ins_valid), 32'd1);
        check("int_data", 32'(ins_to_apctrl), 32'h0BAD_CAFE);
        check("int_rdy", 32'(ins_cache_rdy), 32'd1);
        @(negedge clk);
        ins_req = 1'b0;
        check("int_gap", 32'(ins_valid), 32'd0);
        @(negedge clk);
        check("int_then_ins", 32'(ins_valid), 32'd1);
        check("int_then_data", 32'(ins_to_apctrl), 32'(ddr_word(7)));

        // Flush during refill of line 1: word still returned, line not kept.
        fetch(40);
        check("fl_rreq", 32'(ins_read_req), 32'd1);
        check("fl_raddr", 32'(ins_read_addr), 32'd256);
        check("fl_miss", 32'(miss_cnt), 32'd2);
        burst(32, 32, 5);
        wait_valid(1'b0, seen);
        check("fl_valid", 32'(seen), 32'd1);
        check("fl_data", 32'(ins_to_apctrl), 32'(ddr_word(40)));
        fetch(40);
        check("fl_rehit_valid", 32'(ins_valid), 32'd0);
        check("fl_remiss_rreq", 32'(ins_read_req), 32'd1);
        check("fl_remiss_cnt", 32'(miss_cnt), 32'd3);
        burst(32, 32, -1);
        wait_valid(1'b0, seen);
        check("fl_re_data", 32'(ins_to_apctrl), 32'(ddr_word(40)));
        fetch(41);
        check("fl_hit41", 32'(ins_valid), 32'd1);
        check("fl_hit41_data", 32'(ins_to_apctrl), 32'(ddr_word(41)));

        // Address 130: out of range for 128, short tail line for 140.
        fetch(130);
        check("oor_valid", 32'(ins_valid), 32'd1);
        check("oor_err", 32'(ins_err), 32'd1);
        check("oor_data", 32'(ins_to_apctrl), 32'd0);
        check("oor_rreq", 32'(ins_read_req), 32'd0);
        check("tail_rreq", 32'(ins_read_req_b), 32'd1);
        check("tail_raddr", 32'(ins_read_addr_b), 32'd1024);
        check("tail_rlen", 32'(ins_read_len_b), 32'd12);
        check("tail_miss", 32'(miss_cnt_b), 32'd4);
        burst(128, 12, -1);
        check("oor_beats_ignored", 32'(miss_cnt), 32'd3);
        wait_valid(1'b1, seen);
        check("tail_valid", 32'(seen), 32'd1);
        check("tail_data", 32'(ins_to_apctrl_b), 32'(ddr_word(130)));
        check("tail_err", 32'(ins_err_b), 32'd0);

        // Reset dropped at beat 10 of a refill.
        fetch(70);
        check("rr_rreq", 32'(ins_read_req), 32'd1);
        check("rr_raddr", 32'(ins_read_addr), 32'd512);
        check("rr_miss", 32'(miss_cnt), 32'd4);
        burst(64, 10, -1);
        rst = 1'b0;
        rd_burst_data_valid = 1'b1;
        ins_to_cache = 30'h3FFF_FFFF;
        #1;
        check("rr_rreq_now", 32'(ins_read_req), 32'd0);
        check("rr_miss_now", 32'(miss_cnt), 32'd0);
        check("rr_rdy_now", 32'(ins_cache_rdy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rd_burst_data_valid = 1'b0;
        check("rr_idle_rdy", 32'(ins_cache_rdy), 32'd1);
        check("rr_no_valid", 32'(ins_valid), 32'd0);
        fetch(70);
        check("rr_remiss_rreq", 32'(ins_read_req), 32'd1);
        check("rr_remiss_cnt", 32'(miss_cnt), 32'd1);
        burst(64, 32, -1);
        wait_valid(1'b0, seen);
        check("rr_valid", 32'(seen), 32'd1);
        check("rr_data", 32'(ins_to_apctrl), 32'(ddr_word(70)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
